// File: rtl/ocr_block_reader.sv
// Avalon-MM block read master feeding an Avalon-ST source through a small credit-managed FIFO.
// Define OCR_RD_CHECKSUM_EN to add a running sum of accepted stream words on `checksum`.
module ocr_block_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 11,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
`ifdef OCR_RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  issued_d;
  logic [LEN_W-1:0]  acc_q;
  logic              cs_q;
  logic              busy_q;
  logic              done_q;

  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [DATA_W-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      outstanding_q;
  logic [CNT_W-1:0]      outstanding_d;
  logic                  push;
  logic                  pop;

  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign m_chipselect = cs_q;
  assign m_address    = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

  assign push      = rd_vld_q[RD_LATENCY-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_mem_q[rd_ptr_q];
  assign out_sop   = out_valid && (acc_q == '0);
  assign out_eop   = out_valid && (acc_q == len_q - 1'b1);

  // outstanding = words in the FIFO plus reads still in the RAM pipeline;
  // a push only moves a word between the two, so it leaves the sum unchanged.
  always_comb begin
    issued_d      = issued_q + LEN_W'(cs_q);
    outstanding_d = outstanding_q + CNT_W'(cs_q) - CNT_W'(pop);
  end

  // ---- read-return pipeline and output FIFO control ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      rd_vld_q[0] <= cs_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
      end
      outstanding_q <= outstanding_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= m_readdata;
  end

  // ---- transfer FSM; chipselect/address are registered one cycle ahead ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      acc_q    <= '0;
      cs_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (pop) acc_q <= acc_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (cmd_start) begin
            base_q   <= cmd_base;
            len_q    <= cmd_len;
            issued_q <= '0;
            acc_q    <= '0;
            if (cmd_len != '0) begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              addr_q  <= cmd_base;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          issued_q <= issued_d;
          if (issued_d == len_q) begin
            state_q <= S_DRAIN;
            cs_q    <= 1'b0;
          end else begin
            cs_q   <= (outstanding_d < CNT_W'(FIFO_DEPTH));
            addr_q <= base_q + ADDR_W'(issued_d);
          end
        end
        S_DRAIN: begin
          if (pop && out_eop) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef OCR_RD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  assign checksum = sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE && cmd_start) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_ocr_block_reader.sv
// Directed bench for ocr_block_reader against a fixed-latency RAM model.
module tb_ocr_block_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              cmd_start = 1'b0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect, m_write, m_clken;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_sop, out_eop;
  logic              out_ready = 1'b0;
`ifdef OCR_RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] ram [1024];
  logic [DATA_W-1:0] rd_q;

  always #5 clk = ~clk;

  ocr_block_reader dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .busy(busy), .done(done), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_byteenable(m_byteenable), .m_clken(m_clken), .m_readdata(m_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop)
`ifdef OCR_RD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // RAM port with one cycle of read latency
  always @(posedge clk) begin
    if (m_chipselect) rd_q <= ram[m_address];
  end
  assign m_readdata = rd_q;

  int n_tests = 0;
  int n_fail  = 0;

  int r_words, r_cs, r_cs_stall, r_done_k, r_first_cs, r_first_vld, r_sop_k, r_eop_k, r_nvld, r_busy_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one command; k=0 is the start cycle. out_ready is low for k=1..stall.
  // At k==pulse_k a second (to-be-ignored) start is pulsed.
  task automatic do_xfer(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                         input int stall, input int pulse_k, input string tag);
    logic [ADDR_W-1:0] a;
    r_words = 0; r_cs = 0; r_cs_stall = 0; r_done_k = -1; r_first_cs = -1;
    r_first_vld = -1; r_sop_k = -1; r_eop_k = -1; r_nvld = 0; r_busy_at_done = -1;
    @(negedge clk);
    cmd_base  = base;
    cmd_len   = len;
    cmd_start = 1'b1;
    out_ready = (stall == 0);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == pulse_k) begin
        cmd_start = 1'b1;
        cmd_base  = 10'h100;
        cmd_len   = 11'd5;
      end else begin
        cmd_start = 1'b0;
      end
      out_ready = (k > stall);
      if (done) begin
        r_done_k = k;
        r_busy_at_done = int'(busy);
        break;
      end
      if (m_chipselect) begin
        if (r_first_cs < 0) r_first_cs = k;
        a = ADDR_W'(int'(base) + r_cs);
        check({tag, "-addr"}, m_address, a);
        r_cs++;
        if (k <= stall) r_cs_stall++;
      end
      if (out_valid) begin
        r_nvld++;
        if (r_first_vld < 0) r_first_vld = k;
      end
      if (out_valid && out_ready) begin
        if (r_words < int'(len)) begin
          a = ADDR_W'(int'(base) + r_words);
          check({tag, "-data"}, out_data, ram[a]);
          check({tag, "-sop"}, out_sop, r_words == 0);
          check({tag, "-eop"}, out_eop, r_words == int'(len) - 1);
          if (out_sop) r_sop_k = k;
          if (out_eop) r_eop_k = k;
        end else begin
          check({tag, "-extra_word"}, r_words, len);
        end
        r_words++;
      end
    end
    cmd_start = 1'b0;
    if (r_done_k < 0) check({tag, "-done_timeout"}, 0, 1);
    check({tag, "-words"}, r_words, len);
    check({tag, "-reads"}, r_cs, len);
    check({tag, "-busy_at_done"}, r_busy_at_done, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(i);

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst-ctrl", {busy, done, m_chipselect, out_valid, out_sop, out_eop}, 6'b0);
    check("rst-addr", m_address, 10'h000);
    check("tied", {m_write, m_byteenable, m_clken}, 6'b0_1111_1);
`ifdef OCR_RD_CHECKSUM_EN
    check("rst-checksum", checksum, 32'h0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic transfer with cycle-accurate latency
    do_xfer(10'h010, 11'd4, 0, -1, "t1");
    check("t1-first_cs", r_first_cs, 1);
    check("t1-first_vld", r_first_vld, 3);
    check("t1-sop_cycle", r_sop_k, 3);
    check("t1-eop_cycle", r_eop_k, 6);
    check("t1-done_cycle", r_done_k, 7);

    // 2: address wrap 0x3FE -> 0x001
    do_xfer(10'h3FE, 11'd4, 0, -1, "t2");

    // 3: long stall; credit limit caps reads at FIFO depth
    do_xfer(10'h040, 11'd16, 20, -1, "t3");
    check("t3-reads_during_stall", r_cs_stall, 4);

    // 4: zero length and an ignored mid-transfer start
    do_xfer(10'h005, 11'd0, 0, -1, "t4a");
    check("t4a-done_cycle", r_done_k, 1);
    check("t4a-valid_cycles", r_nvld, 0);
    do_xfer(10'h080, 11'd8, 0, 3, "t4b");

    // 5: reset on the third output word, then a fresh 2-word transfer
    @(negedge clk);
    cmd_base = 10'h020; cmd_len = 11'd8; cmd_start = 1'b1; out_ready = 1'b1;
    begin
      int idx = 0;
      bit hit = 0;
      for (int k = 1; k <= 50; k++) begin
        @(negedge clk);
        cmd_start = 1'b0;
        if (out_valid && idx == 2) begin
          reset_n = 1'b0;
          hit = 1;
          break;
        end
        if (out_valid) idx++;
      end
      check("t5-reached_word3", hit, 1);
    end
    #1;
    check("t5-rst-ctrl", {busy, done, m_chipselect, out_valid, out_sop, out_eop}, 6'b0);
    check("t5-rst-addr", m_address, 10'h000);
    @(negedge clk);
    reset_n = 1'b1;
    do_xfer(10'h000, 11'd2, 0, -1, "t5");

`ifdef OCR_RD_CHECKSUM_EN
    // 6: checksum wraps mod 2^32
    ram[0] = 32'h1; ram[1] = 32'h2; ram[2] = 32'h3; ram[3] = 32'hFFFF_FFFF;
    do_xfer(10'h000, 11'd4, 0, -1, "t6");
    check("t6-checksum_at_done", checksum, 32'h0000_0005);
    @(negedge clk);
    check("t6-checksum_hold", checksum, 32'h0000_0005);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
